// File: rtl/pe_seq_ctrl_pkg.sv
// Shared types and widths for the pe_core job sequencer.
package pe_ctrl_pkg;

    localparam int PE_SUM_W = 24;
    localparam int OPND_W   = 8;
    localparam int STATE_W  = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_CLR   = 3'd1;
    localparam logic [STATE_W-1:0] S_FETCH = 3'd2;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd3;
    localparam logic [STATE_W-1:0] S_ISSUE = 3'd4;
    localparam logic [STATE_W-1:0] S_WAIT  = 3'd5;
    localparam logic [STATE_W-1:0] S_OUT   = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = S_IDLE,
        CLR   = S_CLR,
        FETCH = S_FETCH,
        LOAD  = S_LOAD,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        OUT   = S_OUT
    } state_e;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job, operand-buffer, PE and result signals of one sequencer lane.
interface pe_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
);
    import pe_ctrl_pkg::*;

    logic                job_vld;
    logic                job_rdy;
    logic [ADDR_W-1:0]   job_base;
    logic [LEN_W-1:0]    job_len;
    logic                job_mode;

    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_rd_addr;
    logic [OPND_W-1:0]   mem_a;
    logic [OPND_W-1:0]   mem_b;

    logic                pe_reset;
    logic                pe_read_in;
    logic                pe_mode_sel;
    logic [OPND_W-1:0]   pe_a_mul;
    logic [OPND_W-1:0]   pe_b_mul;
    logic                pe_out_vld;
    logic [PE_SUM_W-1:0] pe_pro_sum;

    logic                res_vld;
    logic                res_rdy;
    logic [PE_SUM_W-1:0] res_data;
    logic                res_err;
    logic                busy;

    // master = the sequencer, slave = scheduler / buffer / PE side
    modport master (
        input  job_vld, job_base, job_len, job_mode,
        input  mem_a, mem_b, pe_out_vld, pe_pro_sum, res_rdy,
        output job_rdy, mem_rd_en, mem_rd_addr,
        output pe_reset, pe_read_in, pe_mode_sel, pe_a_mul, pe_b_mul,
        output res_vld, res_data, res_err, busy
    );

    modport slave (
        output job_vld, job_base, job_len, job_mode,
        output mem_a, mem_b, pe_out_vld, pe_pro_sum, res_rdy,
        input  job_rdy, mem_rd_en, mem_rd_addr,
        input  pe_reset, pe_read_in, pe_mode_sel, pe_a_mul, pe_b_mul,
        input  res_vld, res_data, res_err, busy
    );

endinterface

// File: rtl/pe_seq_ctrl_wait_timer.sv
// Loadable down-counter that flags the last permitted cycle of a PE wait.
module pe_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_reg;

    // Loaded with TIMEOUT_CYC-1 so the flag rises on the TIMEOUT_CYC-th enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign expired = en && (cnt_reg == '0);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Dot-product job sequencer for one pe_core MAC lane.
module pe_seq_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CLR_CYC     = 1
) (
    input  logic          clk,
    input  logic          reset,
    pe_seq_ctrl_if.master bus
);
    import pe_ctrl_pkg::*;

    localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    logic [STATE_W-1:0]  state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [LEN_W-1:0]    idx_reg;
    logic                mode_reg;
    logic [CLR_W-1:0]    clr_cnt_reg;
    logic [OPND_W-1:0]   a_reg;
    logic [OPND_W-1:0]   b_reg;
    logic [PE_SUM_W-1:0] sum_reg;
    logic                err_reg;

    logic job_fire;
    logic last_elem;
    logic wait_expired;
    logic busy_int;
    logic out_int;

    assign job_fire  = (state_reg == S_IDLE) && bus.job_vld;
    assign last_elem = (idx_reg == len_reg - LEN_W'(1));
    assign busy_int  = (state_reg != S_IDLE);
    assign out_int   = (state_reg == S_OUT);

    pe_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (state_reg == S_ISSUE),
        .en      (state_reg == S_WAIT),
        .expired (wait_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.job_vld) state_next = (bus.job_len == '0) ? S_OUT : S_CLR;
            S_CLR:   if (clr_cnt_reg == '0) state_next = S_FETCH;
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            // A result arriving on the expiry cycle still wins over the timeout.
            S_WAIT: begin
                if (bus.pe_out_vld) begin
                    state_next = last_elem ? S_OUT : S_FETCH;
                end else if (wait_expired) begin
                    state_next = S_OUT;
                end
            end
            S_OUT:   if (bus.res_rdy) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            base_reg    <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            mode_reg    <= 1'b0;
            clr_cnt_reg <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (job_fire) begin
                base_reg    <= bus.job_base;
                len_reg     <= bus.job_len;
                mode_reg    <= bus.job_mode;
                idx_reg     <= '0;
                sum_reg     <= '0;
                err_reg     <= 1'b0;
                clr_cnt_reg <= CLR_W'(CLR_CYC - 1);
            end
            if ((state_reg == S_CLR) && (clr_cnt_reg != '0)) begin
                clr_cnt_reg <= clr_cnt_reg - CLR_W'(1);
            end
            // Operands move only here so the PE sees them stable through ISSUE and WAIT.
            if (state_reg == S_LOAD) begin
                a_reg <= bus.mem_a;
                b_reg <= bus.mem_b;
            end
            if (state_reg == S_WAIT) begin
                if (bus.pe_out_vld) begin
                    sum_reg <= bus.pe_pro_sum;
                    if (!last_elem) idx_reg <= idx_reg + LEN_W'(1);
                end else if (wait_expired) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.job_rdy     = (state_reg == S_IDLE) && !reset;
    assign bus.busy        = busy_int;
    assign bus.mem_rd_en   = (state_reg == S_FETCH);
    assign bus.mem_rd_addr = (state_reg == S_FETCH) ? (base_reg + ADDR_W'(idx_reg)) : '0;
    assign bus.pe_reset    = reset || (state_reg == S_CLR);
    assign bus.pe_read_in  = (state_reg == S_ISSUE);
    assign bus.pe_mode_sel = busy_int && mode_reg;
    assign bus.pe_a_mul    = a_reg;
    assign bus.pe_b_mul    = b_reg;
    assign bus.res_vld     = out_int;
    assign bus.res_data    = out_int ? sum_reg : '0;
    assign bus.res_err     = out_int && err_reg;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl with an operand buffer and a delay-programmable PE model.
module tb_pe_seq_ctrl;
    localparam int ADDR_W      = 8;
    localparam int LEN_W       = 8;
    localparam int TIMEOUT_CYC = 15;
    localparam int CLR_CYC     = 1;
    localparam int DEAD        = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

    pe_seq_ctrl #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_miss = 0;

    // Operand buffer contents and per-address PE response delay (DEAD = never answers)
    logic [7:0] mem_a_arr [256];
    logic [7:0] mem_b_arr [256];
    int         dly_arr   [256];
    logic [7:0] last_addr = 8'd0;

    function automatic int mul(input logic [7:0] a, input logic [7:0] b);
        return int'(a) * int'($signed(b));
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_a <= mem_a_arr[bus.mem_rd_addr];
            bus.mem_b <= mem_b_arr[bus.mem_rd_addr];
            last_addr <= bus.mem_rd_addr;
        end
    end

    // PE: delay d puts out_vld in the (d+1)-th cycle after the read strobe
    int pe_acc = 0;
    int pe_prod = 0;
    int pe_cnt = -1;
    always @(posedge clk) begin
        if (bus.pe_reset) begin
            pe_acc <= 0; pe_cnt <= -1; bus.pe_out_vld <= 1'b0; bus.pe_pro_sum <= '0;
        end else if (bus.pe_read_in && dly_arr[last_addr] != DEAD) begin
            if (dly_arr[last_addr] == 0) begin
                pe_acc <= pe_acc + mul(bus.pe_a_mul, bus.pe_b_mul);
                bus.pe_pro_sum <= 24'(pe_acc + mul(bus.pe_a_mul, bus.pe_b_mul));
                bus.pe_out_vld <= 1'b1;
                pe_cnt <= -1;
            end else begin
                pe_prod <= mul(bus.pe_a_mul, bus.pe_b_mul);
                pe_cnt <= dly_arr[last_addr] - 1;
                bus.pe_out_vld <= 1'b0;
            end
        end else if (pe_cnt == 0) begin
            pe_acc <= pe_acc + pe_prod;
            bus.pe_pro_sum <= 24'(pe_acc + pe_prod);
            bus.pe_out_vld <= 1'b1;
            pe_cnt <= -1;
        end else begin
            bus.pe_out_vld <= 1'b0;
            if (pe_cnt > 0) pe_cnt <= pe_cnt - 1;
        end
    end

    // Activity monitor
    int rd_cnt = 0, rdin_cnt = 0, clr_cnt = 0, mode_bad = 0, clr_last_rd = 0;
    logic [7:0]  addr_log [256];
    logic [15:0] op_log   [256];
    logic        cur_mode = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_rd_en) begin
                addr_log[rd_cnt[7:0]] <= bus.mem_rd_addr;
                rd_cnt <= rd_cnt + 1;
            end
            if (bus.pe_read_in) begin
                op_log[rdin_cnt[7:0]] <= {bus.pe_a_mul, bus.pe_b_mul};
                rdin_cnt <= rdin_cnt + 1;
            end
            if (bus.pe_reset) begin
                clr_cnt <= clr_cnt + 1;
                clr_last_rd <= rd_cnt;
            end
            if (bus.pe_mode_sel !== (bus.busy ? cur_mode : 1'b0)) mode_bad <= mode_bad + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
        end
    endtask

    // Reference: result, error, elements touched and handshake-to-res_vld cycles
    task automatic ref_job(input logic [7:0] base, input logic [7:0] len,
                           output int res, output logic err, output int p, output int lat);
        res = 0; err = 1'b0; p = 0; lat = 1;
        if (len != 0) begin
            lat += CLR_CYC;
            for (int i = 0; i < int'(len); i++) begin
                int a;
                a = (int'(base) + i) % 256;
                p++;
                if (dly_arr[a] < TIMEOUT_CYC) begin
                    res += mul(mem_a_arr[a], mem_b_arr[a]);
                    lat += 4 + dly_arr[a];
                end else begin
                    err = 1'b1;
                    lat += 3 + TIMEOUT_CYC;
                    break;
                end
            end
        end
    endtask

    task automatic start_job(input logic [7:0] base, input logic [7:0] len, input logic mode);
        check("job_rdy_idle", bus.job_rdy, 1'b1);
        bus.job_base = base; bus.job_len = len; bus.job_mode = mode;
        bus.job_vld = 1'b1;
        cur_mode = mode;
        @(posedge clk);
        #1 bus.job_vld = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] base, input logic [7:0] len, input logic mode,
                           input int hold, output int res, output logic err);
        int e_res, e_p, e_lat, lat, s_rd, s_rdin, s_clr, s_mode;
        logic e_err, r_err;
        logic [23:0] r0;
        ref_job(base, len, e_res, e_err, e_p, e_lat);
        s_rd = rd_cnt; s_rdin = rdin_cnt; s_clr = clr_cnt; s_mode = mode_bad;
        start_job(base, len, mode);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.res_vld && lat < 600);
        check("res_latency", lat, e_lat);
        res = int'($signed(bus.res_data));
        err = bus.res_err;
        r0 = bus.res_data; r_err = bus.res_err;
        check("res_data", res, e_res);
        check("res_err", err, e_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable", {bus.res_vld, bus.res_data, bus.res_err, bus.job_rdy, bus.busy},
                  {1'b1, r0, r_err, 1'b0, 1'b1});
        end
        bus.res_rdy = 1'b1;
        @(posedge clk);
        #1 bus.res_rdy = 1'b0;
        @(negedge clk);
        check("idle_after_ack", {bus.res_vld, bus.busy, bus.job_rdy}, 3'b001);
        check("rd_pulses", rd_cnt - s_rd, e_p);
        check("read_in_pulses", rdin_cnt - s_rdin, e_p);
        check("clr_cycles", clr_cnt - s_clr, (len != 0) ? CLR_CYC : 0);
        if (len != 0) check("clr_before_fetch", clr_last_rd, s_rd);
        check("mode_sel", mode_bad - s_mode, 0);
        for (int k = 0; k < e_p; k++) begin
            int a;
            a = (int'(base) + k) % 256;
            check("rd_addr", addr_log[(s_rd + k) % 256], a);
            check("pe_operands", op_log[(s_rdin + k) % 256], {mem_a_arr[a], mem_b_arr[a]});
        end
    endtask

    task automatic rst_check(input string name);
        check(name, {bus.pe_reset, bus.job_rdy, bus.busy, bus.res_vld, bus.res_err,
                     bus.mem_rd_en, bus.pe_read_in, bus.pe_mode_sel}, 8'b1000_0000);
        check({name, "_data"}, {bus.res_data, bus.pe_a_mul, bus.pe_b_mul, bus.mem_rd_addr}, 48'd0);
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        logic       mode;
        int         hold;
        int         exp_res;
        logic       exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int r, cnt, guard, seen;
        logic e;

        bus.job_vld = 1'b0; bus.job_base = '0; bus.job_len = '0; bus.job_mode = 1'b0;
        bus.res_rdy = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a_arr[i] = 8'd0; mem_b_arr[i] = 8'd0; dly_arr[i] = 0;
        end
        mem_a_arr[0] = 8'd5;   mem_b_arr[0] = 8'd3;
        mem_a_arr[1] = 8'd10;  mem_b_arr[1] = 8'hFE;
        mem_a_arr[2] = 8'd255; mem_b_arr[2] = 8'd127;
        mem_a_arr[3] = 8'd2;   mem_b_arr[3] = 8'd4;
        mem_a_arr[10] = 8'd7;  mem_b_arr[10] = 8'd7;
        mem_a_arr[11] = 8'd9;  mem_b_arr[11] = 8'd9;  dly_arr[11] = DEAD;
        dly_arr[20] = DEAD;
        mem_a_arr[30] = 8'd3;  mem_b_arr[30] = 8'hFC; dly_arr[30] = TIMEOUT_CYC - 1;
        mem_a_arr[31] = 8'd6;  mem_b_arr[31] = 8'd6;  dly_arr[31] = TIMEOUT_CYC;
        mem_a_arr[255] = 8'd4; mem_b_arr[255] = 8'd5;
        mem_a_arr[40] = 8'd1;  mem_b_arr[40] = 8'd1;  dly_arr[40] = 2;
        mem_a_arr[41] = 8'd2;  mem_b_arr[41] = 8'hFD; dly_arr[41] = 5;
        mem_a_arr[42] = 8'd100; mem_b_arr[42] = 8'h9C;

        vecs[0] = '{8'd0,   8'd3, 1'b0, 0, 32380,  1'b0};
        vecs[1] = '{8'd3,   8'd1, 1'b0, 0, 8,      1'b0};
        vecs[2] = '{8'd0,   8'd0, 1'b1, 0, 0,      1'b0};
        vecs[3] = '{8'd1,   8'd2, 1'b1, 5, 32365,  1'b0};
        vecs[4] = '{8'd10,  8'd2, 1'b0, 1, 49,     1'b1};
        vecs[5] = '{8'd20,  8'd2, 1'b0, 0, 0,      1'b1};
        vecs[6] = '{8'd30,  8'd1, 1'b1, 0, -12,    1'b0};
        vecs[7] = '{8'd31,  8'd1, 1'b0, 0, 0,      1'b1};
        vecs[8] = '{8'd255, 8'd2, 1'b0, 2, 35,     1'b0};
        vecs[9] = '{8'd40,  8'd3, 1'b0, 0, -10005, 1'b0};

        repeat (3) @(negedge clk);
        rst_check("reset_outputs");
        reset = 1'b0;
        @(negedge clk);
        check("job_rdy_after_reset", {bus.job_rdy, bus.pe_reset}, 2'b10);

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].hold, r, e);
            check("tbl_res", r, vecs[i].exp_res);
            check("tbl_err", e, vecs[i].exp_err);
        end

        // Reset while element 1 of a len=3 job is waiting on the PE
        cnt = 0; guard = 0;
        start_job(8'd40, 8'd3, 1'b1);
        while (cnt < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (bus.pe_read_in) cnt++;
        end
        check("mid_job_issue", cnt, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rst_check("mid_job_reset");
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_vld) seen++;
        end
        check("no_res_after_reset", seen, 0);
        run_job(8'd0, 8'd1, 1'b0, 0, r, e);
        check("fresh_job_res", r, 15);
        check("fresh_job_err", e, 1'b0);

        // Random jobs over randomized buffer contents and PE delays
        for (int i = 0; i < 256; i++) begin
            int sel;
            mem_a_arr[i] = 8'($urandom);
            mem_b_arr[i] = 8'($urandom);
            sel = int'($urandom_range(0, 19));
            if (sel < 12)       dly_arr[i] = int'($urandom_range(0, 3));
            else if (sel == 12) dly_arr[i] = TIMEOUT_CYC - 1;
            else if (sel == 13) dly_arr[i] = TIMEOUT_CYC;
            else if (sel == 14) dly_arr[i] = TIMEOUT_CYC + 1;
            else if (sel == 15) dly_arr[i] = DEAD;
            else                dly_arr[i] = int'($urandom_range(4, 10));
        end
        for (int j = 0; j < 40; j++) begin
            run_job(8'($urandom), 8'($urandom_range(0, 6)), 1'($urandom),
                    int'($urandom_range(0, 3)), r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
Job sequencer for one pe_core MAC lane. It accepts a dot-product job (base address, length, mode) and clears the PE accumulator. For each element it fetches one unsigned/signed operand pair from a 1-cycle-latency operand buffer, pulses the PE read strobe, and waits for the PE's out_vld. It returns the final 24-bit pro_sum on a valid/ready result port and sits between the layer scheduler and the PE array.

Parameters:
ADDR_W, 8, operand buffer address width
LEN_W, 8, job length width (max elements = 2**LEN_W-1)
TIMEOUT_CYC, 15, max cycles in WAIT before aborting the job
CLR_CYC, 1, cycles pe_reset is held at job start (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
job_vld  in  1  job request
job_rdy  out  1  controller idle, job accepted when job_vld&&job_rdy
job_base  in  ADDR_W  first operand address
job_len  in  LEN_W  element count
job_mode  in  1  PE mode_sel for whole job
mem_rd_en  out  1  operand read strobe
mem_rd_addr  out  ADDR_W  operand address
mem_a  in  8  unsigned operand, valid cycle after mem_rd_en
mem_b  in  8  signed operand, valid cycle after mem_rd_en
pe_reset  out  1  PE reset (= reset OR clear)
pe_read_in  out  1  one-cycle PE step strobe
pe_mode_sel  out  1  PE mode
pe_a_mul  out  8  unsigned operand to PE
pe_b_mul  out  8  signed operand to PE
pe_out_vld  in  1  PE step result valid
pe_pro_sum  in  24  signed PE result
res_vld  out  1  result valid
res_rdy  in  1  result accepted when res_vld&&res_rdy
res_data  out  24  signed final sum
res_err  out  1  job aborted by timeout
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high. Reset forces state IDLE and zeroes every register.
- Reset values: all outputs 0, except pe_reset=1 while reset is high. job_rdy=1 in the first cycle after reset deasserts.
- FSM: IDLE -> CLR -> FETCH -> LOAD -> ISSUE -> WAIT -> (FETCH | OUT) -> IDLE.
- IDLE: job_rdy=1. On handshake, latch base, len and mode, and set idx=0. If len==0, go to OUT with res_data=0 and res_err=0; no PE or memory activity. Otherwise go to CLR.
- CLR: pe_reset=1 for CLR_CYC cycles, then FETCH.
- FETCH: mem_rd_en=1 for exactly one cycle, mem_rd_addr=base+idx (wraps modulo 2**ADDR_W).
- LOAD: capture mem_a/mem_b into operand registers. pe_a_mul/pe_b_mul change only here and stay stable through ISSUE and WAIT.
- ISSUE: pe_read_in=1 for exactly one cycle.
- WAIT: count cycles.
  - On pe_out_vld, capture pe_pro_sum into sum_q. If idx==len-1, go to OUT; else increment idx and go to FETCH.
  - If the wait count reaches TIMEOUT_CYC without pe_out_vld, go to OUT with res_err=1 and res_data=sum_q (last good sum, 0 if none).
- pe_out_vld outside WAIT is ignored. pe_out_vld on the same cycle as the timeout expiry counts as a valid result, with no error.
- pe_mode_sel = latched mode from CLR through OUT; 0 in IDLE.
- OUT: res_vld=1. res_data and res_err are held stable until res_rdy; on handshake go to IDLE. job_rdy=0 throughout OUT, so there is no result/job overlap.
- Per-element latency: 4 cycles minimum (FETCH, LOAD, ISSUE, 1-cycle WAIT).
- Job latency: CLR_CYC + 4*len + PE wait cycles + 1 OUT cycle minimum.
- Width: idx is LEN_W bits; comparison uses len-1 with len!=0 guaranteed. No arithmetic on pe_pro_sum; it is passed through 24-bit signed.
- Reset mid-job: abandon immediately. No res_vld is produced. pe_reset is asserted by the external reset. The next job starts clean.

Decomposition:
- Shared package pe_ctrl_pkg holds: state enum typedef (IDLE, CLR, FETCH, LOAD, ISSUE, WAIT, OUT), the PE_SUM_W=24 constant, and the operand widths (8).
- Optional sub-module pe_wait_timer: loadable down-counter with an expiry flag, used by WAIT.
- Everything else lives in one module.

Test Plan:
- Instantiate with a real pe_core and memory {0:(5,3),1:(10,-2),2:(255,127)}. Job base=0, len=3, mode=0 -> res_data=32380, res_err=0, exactly 3 pe_read_in pulses and 3 mem_rd_en pulses, addresses 0,1,2.
- Back-to-back jobs: after the above, job base=3 (mem[3]=(2,4)), len=1 -> res_data=8, not 32388; pe_reset seen for CLR_CYC cycles before the first fetch.
- len=0 -> res_vld one cycle after the handshake, res_data=0, no mem_rd_en, no pe_read_in, no pe_reset pulse.
- Backpressure: hold res_rdy=0 for 5 cycles -> res_vld, res_data and res_err stable, job_rdy=0 and busy=1 throughout; IDLE the cycle after res_rdy=1.
- Timeout: stub PE that never asserts out_vld, len=2 -> res_err=1 and res_data=0 exactly TIMEOUT_CYC WAIT cycles after the single pe_read_in; the next job runs normally.
- Reset asserted during the WAIT of element 1 of a len=3 job -> next cycle all outputs at reset values and no res_vld; a fresh len=1 job (5,3) returns 15.
